// File: rtl/hsv2rgb.sv
// ============================================================================
//  Module      : hsv2rgb
//  Description : 6-stage streaming HSV to RGB converter, one pixel per clock.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hsv2rgb (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_hue,
    input  logic [7:0] in_saturation,
    input  logic [7:0] in_brightness,
    input  logic       in_visual,
    input  logic       in_done,
    output logic       out_valid,
    output logic [7:0] out_red,
    output logic [7:0] out_green,
    output logic [7:0] out_blue,
    output logic [7:0] out_hue,
    output logic [7:0] out_saturation,
    output logic [7:0] out_brightness,
    output logic       out_visual,
    output logic       out_done
);

    localparam int STAGES = 6;
    localparam int SB_W   = 27;

    // Sideband word: {valid, visual, done, hue, saturation, brightness}
    logic [SB_W-1:0] side_q [1:STAGES];
    logic [SB_W-1:0] side_d [1:STAGES];
    logic [2:0]      sec_q  [1:5];
    logic [2:0]      sec_d  [1:5];

    logic [7:0]  f_q, f_d;
    logic [15:0] sf_q, sf_d, snf_q, snf_d, vns_q, vns_d;
    logic [7:0]  a_q, a_d, b_q, b_d, p3_q, p3_d;
    logic [15:0] qn_q, qn_d, tn_q, tn_d;
    logic [7:0]  p4_q, p4_d, q_q, q_d, t_q, t_d, p5_q, p5_d;
    logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [10:0] h6;
    logic [7:0]  sat1, v1, v3, v5;

    // Exact floor(x/255) for x in 0..65025 without a divider.
    function automatic logic [7:0] div255(input logic [15:0] x);
        logic [16:0] t;
        t = {1'b0, x} + {9'd0, x[15:8]} + 17'd1;
        return 8'(t >> 8);
    endfunction

    assign sat1 = side_q[1][15:8];
    assign v1   = side_q[1][7:0];
    assign v3   = side_q[3][7:0];
    assign v5   = side_q[5][7:0];

    always_comb begin
        side_d[1] = {in_valid, in_visual, in_done, in_hue, in_saturation, in_brightness};
        for (int k = 2; k <= STAGES; k++) side_d[k] = side_q[k-1];

        h6       = {3'd0, in_hue} * 11'd6;
        sec_d[1] = h6[10:8];
        f_d      = h6[7:0];
        for (int k = 2; k <= 5; k++) sec_d[k] = sec_q[k-1];

        sf_d  = {8'd0, sat1} * {8'd0, f_q};
        snf_d = {8'd0, sat1} * {8'd0, 8'd255 - f_q};
        vns_d = {8'd0, v1}   * {8'd0, 8'd255 - sat1};

        a_d  = div255(sf_q);
        b_d  = div255(snf_q);
        p3_d = div255(vns_q);

        qn_d = {8'd0, v3} * {8'd0, 8'd255 - a_q};
        tn_d = {8'd0, v3} * {8'd0, 8'd255 - b_q};
        p4_d = p3_q;

        q_d  = div255(qn_q);
        t_d  = div255(tn_q);
        p5_d = p4_q;

        red_d   = 8'd0;
        green_d = 8'd0;
        blue_d  = 8'd0;
        case (sec_q[5])
            3'd0:    begin red_d = v5;   green_d = t_q;  blue_d = p5_q; end
            3'd1:    begin red_d = q_q;  green_d = v5;   blue_d = p5_q; end
            3'd2:    begin red_d = p5_q; green_d = v5;   blue_d = t_q;  end
            3'd3:    begin red_d = p5_q; green_d = q_q;  blue_d = v5;   end
            3'd4:    begin red_d = t_q;  green_d = p5_q; blue_d = v5;   end
            3'd5:    begin red_d = v5;   green_d = p5_q; blue_d = q_q;  end
            default: begin red_d = 8'd0; green_d = 8'd0; blue_d = 8'd0; end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 1; k <= STAGES; k++) side_q[k] <= '0;
            for (int k = 1; k <= 5; k++)      sec_q[k]  <= '0;
            f_q   <= '0;
            sf_q  <= '0; snf_q <= '0; vns_q <= '0;
            a_q   <= '0; b_q   <= '0; p3_q  <= '0;
            qn_q  <= '0; tn_q  <= '0; p4_q  <= '0;
            q_q   <= '0; t_q   <= '0; p5_q  <= '0;
            red_q <= '0; green_q <= '0; blue_q <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) side_q[k] <= side_d[k];
            for (int k = 1; k <= 5; k++)      sec_q[k]  <= sec_d[k];
            f_q   <= f_d;
            sf_q  <= sf_d;  snf_q <= snf_d; vns_q <= vns_d;
            a_q   <= a_d;   b_q   <= b_d;   p3_q  <= p3_d;
            qn_q  <= qn_d;  tn_q  <= tn_d;  p4_q  <= p4_d;
            q_q   <= q_d;   t_q   <= t_d;   p5_q  <= p5_d;
            red_q <= red_d; green_q <= green_d; blue_q <= blue_d;
        end
    end

    assign out_valid      = side_q[STAGES][26];
    assign out_visual     = side_q[STAGES][25];
    assign out_done       = side_q[STAGES][24];
    assign out_hue        = side_q[STAGES][23:16];
    assign out_saturation = side_q[STAGES][15:8];
    assign out_brightness = side_q[STAGES][7:0];
    assign out_red        = red_q;
    assign out_green      = green_q;
    assign out_blue       = blue_q;

endmodule

`default_nettype wire

// File: tb/tb_hsv2rgb.sv
// ============================================================================
//  Module      : tb_hsv2rgb
//  Description : Directed and streamed checks for the hsv2rgb pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hsv2rgb;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0, in_visual = 1'b0, in_done = 1'b0;
    logic [7:0] in_hue = 8'd0, in_saturation = 8'd0, in_brightness = 8'd0;
    logic       out_valid, out_visual, out_done;
    logic [7:0] out_red, out_green, out_blue, out_hue, out_saturation, out_brightness;

    int total = 0;
    int bad   = 0;

    hsv2rgb dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_hue(in_hue), .in_saturation(in_saturation),
        .in_brightness(in_brightness), .in_visual(in_visual), .in_done(in_done),
        .out_valid(out_valid), .out_red(out_red), .out_green(out_green),
        .out_blue(out_blue), .out_hue(out_hue), .out_saturation(out_saturation),
        .out_brightness(out_brightness), .out_visual(out_visual), .out_done(out_done)
    );

    always #5 clock = ~clock;

    // Packed output word: {valid, visual, done, hue, sat, val, r, g, b}
    function automatic logic [50:0] get_out();
        return {out_valid, out_visual, out_done, out_hue, out_saturation,
                out_brightness, out_red, out_green, out_blue};
    endfunction

    function automatic logic [50:0] model(input logic vld, input logic vis, input logic dn,
                                          input logic [7:0] h, input logic [7:0] s,
                                          input logic [7:0] v);
        int h6, sec, f, a, b, p, q, t, r, g, bl;
        h6 = int'(h) * 6;
        sec = h6 / 256;
        f = h6 % 256;
        a = int'(s) * f / 255;
        b = int'(s) * (255 - f) / 255;
        p = int'(v) * (255 - int'(s)) / 255;
        q = int'(v) * (255 - a) / 255;
        t = int'(v) * (255 - b) / 255;
        case (sec)
            0: begin r = v; g = t; bl = p; end
            1: begin r = q; g = v; bl = p; end
            2: begin r = p; g = v; bl = t; end
            3: begin r = p; g = q; bl = v; end
            4: begin r = t; g = p; bl = v; end
            default: begin r = v; g = p; bl = q; end
        endcase
        return {vld, vis, dn, h, s, v, 8'(r), 8'(g), 8'(bl)};
    endfunction

    task automatic set_in(input logic vld, input logic vis, input logic dn,
                          input logic [7:0] h, input logic [7:0] s, input logic [7:0] v);
        in_valid = vld; in_visual = vis; in_done = dn;
        in_hue = h; in_saturation = s; in_brightness = v;
    endtask

    task automatic test_reset();
        logic [50:0] act;
        reset_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 8'd33, 8'd200, 8'd150);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            act = get_out();
            total++;
            if (act !== 51'd0) begin
                bad++;
                $display("FAIL reset_state edge %0d: got %h want 0", i, act);
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) @(posedge clock);
        #1;
    endtask

    // Hand-computed conversions, streamed back to back.
    task automatic test_vectors();
        logic [50:0] vec [7];
        logic [50:0] exp_q [$];
        logic [50:0] act, e;
        vec[0] = {3'b100, 8'd0,   8'd255, 8'd255, 8'd255, 8'd0,   8'd0};
        vec[1] = {3'b110, 8'd85,  8'd255, 8'd255, 8'd1,   8'd255, 8'd0};
        vec[2] = {3'b100, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0,   8'd5};
        vec[3] = {3'b100, 8'd128, 8'd255, 8'd200, 8'd0,   8'd200, 8'd200};
        vec[4] = {3'b110, 8'd200, 8'd0,   8'd77,  8'd77,  8'd77,  8'd77};
        vec[5] = {3'b100, 8'd43,  8'd255, 8'd255, 8'd253, 8'd255, 8'd0};
        vec[6] = {3'b111, 8'd40,  8'd100, 8'd0,   8'd0,   8'd0,   8'd0};
        for (int j = 0; j < 13; j++) begin
            if (j < 7) begin
                set_in(vec[j][50], vec[j][49], vec[j][48], vec[j][47:40],
                       vec[j][39:32], vec[j][31:24]);
                exp_q.push_back(vec[j]);
            end else begin
                set_in(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
                exp_q.push_back(51'd0);
            end
            @(posedge clock); #1;
            if (j >= 5) begin
                e = exp_q.pop_front();
                act = get_out();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL vector %0d: got %h want %h", j - 5, act, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [50:0] exp_q [$];
        logic [50:0] act, e;
        logic vis, dn;
        for (int j = 0; j < 262; j++) begin
            if (j < 256) begin
                vis = j[0];
                dn  = (j == 255);
                set_in(1'b1, vis, dn, 8'(j), 8'd255, 8'd255);
                exp_q.push_back(model(1'b1, vis, dn, 8'(j), 8'd255, 8'd255));
            end else begin
                set_in(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
                exp_q.push_back(51'd0);
            end
            @(posedge clock); #1;
            if (j >= 5) begin
                e = exp_q.pop_front();
                act = get_out();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL sweep pixel %0d: got %h want %h", j - 5, act, e);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [50:0] act, e;
        for (int j = 0; j < 4; j++) begin
            set_in(1'b1, 1'b1, 1'b1, 8'(60 * j + 10), 8'd180, 8'd220);
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 8'd99, 8'd99, 8'd99);
        @(posedge clock); #1;
        act = get_out();
        total++;
        if (act !== 51'd0) begin
            bad++;
            $display("FAIL midreset_clear: got %h want 0", act);
        end
        reset_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 8'd0, 8'd255, 8'd255);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock); #1;
            set_in(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            e = (k == 6) ? {3'b100, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0} : 51'd0;
            act = get_out();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL post_reset edge %0d: got %h want %h", k, act, e);
            end
        end
    endtask

    task automatic test_random();
        logic [50:0] exp_q [$];
        logic [50:0] act, e;
        logic vld, vis, dn;
        logic [7:0] h, s, v;
        for (int j = 0; j < 406; j++) begin
            if (j < 400) begin
                vld = 1'($urandom_range(0, 1));
                vis = 1'($urandom_range(0, 1));
                dn  = 1'($urandom_range(0, 1));
                h = 8'($urandom_range(0, 255));
                s = 8'($urandom_range(0, 255));
                v = 8'($urandom_range(0, 255));
                if (j % 50 == 0) s = 8'd0;
                if (j % 50 == 1) v = 8'd0;
                set_in(vld, vis, dn, h, s, v);
                exp_q.push_back(model(vld, vis, dn, h, s, v));
            end else begin
                set_in(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
                exp_q.push_back(51'd0);
            end
            @(posedge clock); #1;
            if (j >= 5) begin
                e = exp_q.pop_front();
                act = get_out();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL random pixel %0d: got %h want %h", j - 5, act, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
